datamover_ctrl_fsm: RTL and testbench
=====================================

DATAMOVER_CTRL_FSM -- requirements
Module: datamover_ctrl_fsm

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte-address width of base addresses.
REQ-002 Parameter: LEN_WIDTH, 16, width of the transfer length in 32-bit words.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset; synchronous and active-low.
REQ-005 clear_i  input  1  synchronous soft clear, active-high.
REQ-006 start_i  input  1  one-cycle job trigger.
REQ-007 src_addr_i / dst_addr_i  input  ADDR_WIDTH  source and destination base addresses.
REQ-008 len_i  input  LEN_WIDTH  transfer length in words.
REQ-009 src_req_start_o / snk_req_start_o  output  1  start requests to the source streamer and the sink streamer.
REQ-010 src_base_addr_o / snk_base_addr_o  output  ADDR_WIDTH  latched base addresses.
REQ-011 src_tot_len_o / snk_tot_len_o  output  LEN_WIDTH  latched length.
REQ-012 src_ready_start_i / snk_ready_start_i  input  1  streamer idle and able to accept a start request.
REQ-013 src_done_i / snk_done_i  input  1  one-cycle streamer completion pulse.
REQ-014 tcdm_fifo_empty_i  input  1  sink-side TCDM FIFO empty.
REQ-015 beat_valid_i / beat_ready_i  input  1  observed data_out stream handshake; monitor only.
REQ-016 busy_o  output  1  job in progress.
REQ-017 done_o  output  1  one-cycle job-complete event.
REQ-018 err_o  output  1  sticky protocol error.
REQ-019 beat_cnt_o  output  LEN_WIDTH  count of accepted data_out beats in the current job.

Function
REQ-020 States SHALL be IDLE, ISSUE, RUN, DRAIN and DONE.
REQ-021 IDLE: on start_i with len_i!=0, the FSM SHALL latch addresses and length, clear beat_cnt_o and per-streamer flags, and move to ISSUE in the next cycle.
REQ-022 IDLE: on start_i with len_i==0, the FSM SHALL go directly to DONE and SHALL issue no req_start.
REQ-023 ISSUE: each *_req_start_o SHALL assert combinationally while its start is pending and *_ready_start_i==1; that start SHALL be marked issued in the same cycle (single-cycle request).
REQ-024 A streamer whose ready_start is low SHALL remain pending and retry each cycle; the two streamers are issued independently.
REQ-025 ISSUE SHALL move to RUN once both starts are issued.
REQ-026 *_done_i pulses SHALL be latched into per-streamer done flags in any non-IDLE state, including a pulse that arrives in the same cycle its start is issued or in any later cycle.
REQ-027 beat_cnt_o SHALL increment by 1 on each cycle with beat_valid_i&beat_ready_i while busy_o=1, and SHALL saturate at 2^LEN_WIDTH-1.
REQ-028 RUN SHALL move to DRAIN when both done flags are set.
REQ-029 DRAIN SHALL move to DONE when tcdm_fifo_empty_i==1; the check is evaluated in the cycle of entry, so the minimum dwell is 1 cycle.
REQ-030 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-031 busy_o SHALL be 1 in ISSUE, RUN and DRAIN, and 0 in IDLE and DONE.
REQ-032 start_i SHALL be ignored outside IDLE.
REQ-033 In the cycle of DRAIN->DONE, if beat_cnt_o!=latched length, err_o SHALL set.
REQ-034 err_o SHALL set on snk_done_i while the sink start is still pending.
REQ-035 err_o SHALL clear only on reset, on clear_i, or on an accepted start_i.
REQ-036 Outputs src/snk base_addr and tot_len SHALL hold their latched values until the next accepted start.
REQ-037 clear_i SHALL force IDLE and zero all state in the next cycle, with the same effect as reset; no done_o SHALL be produced.
REQ-038 Reset SHALL take precedence over clear_i, and clear_i SHALL take precedence over start_i.

Reset
REQ-039 While rst_ni==0 at a clock edge, the FSM SHALL enter IDLE and all outputs, counters and flags SHALL be 0, including the latched addresses and lengths.
REQ-040 Reset asserted mid-job SHALL abort without done_o; req_start outputs SHALL be 0 from the first reset cycle.

Verification
REQ-041 Basic job: start with src=0x100, dst=0x200, len=8, both ready_start=1, 8 beats, both done, FIFO empty. Required: both req_start pulse in cycle 1; done_o pulses once; err_o=0; beat_cnt_o=8.
REQ-042 Staggered issue: snk_ready_start_i low for 5 cycles. Required: src_req_start_o pulses once immediately; snk_req_start_o pulses once in the cycle ready rises; state stays ISSUE until then.
REQ-043 Zero length: start with len=0. Required: no req_start; done_o asserts 1 cycle after start; busy_o stays 0.
REQ-044 FIFO drain: both done but tcdm_fifo_empty_i=0 for 3 cycles. Required: busy_o=1 through those cycles; done_o asserts the cycle after empty rises.
REQ-045 Beat mismatch: len=4 with only 3 beats before both done. Required: done_o and err_o=1; err_o clears on the next start.
REQ-046 Abort: clear_i in RUN, then rst_ni low mid-ISSUE on a second job. Required: IDLE, all outputs 0, no done_o; a subsequent job completes normally.

Source files
------------

// File: rtl/datamover_ctrl_fsm.sv
// ======================================================================
// datamover_ctrl_fsm: job sequencer issuing source/sink streamer starts
// Revision: 1.0 - initial release
// ======================================================================
`default_nettype none

module datamover_ctrl_fsm #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  src_req_start_o,
  output logic                  snk_req_start_o,
  output logic [ADDR_WIDTH-1:0] src_base_addr_o,
  output logic [ADDR_WIDTH-1:0] snk_base_addr_o,
  output logic [LEN_WIDTH-1:0]  src_tot_len_o,
  output logic [LEN_WIDTH-1:0]  snk_tot_len_o,
  input  logic                  src_ready_start_i,
  input  logic                  snk_ready_start_i,
  input  logic                  src_done_i,
  input  logic                  snk_done_i,
  input  logic                  tcdm_fifo_empty_i,
  input  logic                  beat_valid_i,
  input  logic                  beat_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [LEN_WIDTH-1:0]  beat_cnt_o
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ISSUE = 3'd1;
  localparam logic [2:0] c_RUN   = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [LEN_WIDTH-1:0] c_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
  logic [ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
  logic [LEN_WIDTH-1:0]  len_q,      len_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  src_pend_q, src_pend_d;
  logic                  snk_pend_q, snk_pend_d;
  logic                  src_done_q, src_done_d;
  logic                  snk_done_q, snk_done_d;
  logic                  err_q,      err_d;

  logic w_busy;
  logic w_src_issue;
  logic w_snk_issue;

  // Requests are suppressed while reset or clear is being applied so no streamer starts on an aborted job.
  assign w_busy      = (state_q == c_ISSUE) || (state_q == c_RUN) || (state_q == c_DRAIN);
  assign w_src_issue = rst_ni && !clear_i && (state_q == c_ISSUE) && src_pend_q && src_ready_start_i;
  assign w_snk_issue = rst_ni && !clear_i && (state_q == c_ISSUE) && snk_pend_q && snk_ready_start_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= c_IDLE;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      src_pend_q <= 1'b0;
      snk_pend_q <= 1'b0;
      src_done_q <= 1'b0;
      snk_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      src_pend_q <= src_pend_d;
      snk_pend_q <= snk_pend_d;
      src_done_q <= src_done_d;
      snk_done_q <= snk_done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    src_pend_d = src_pend_q;
    snk_pend_d = snk_pend_q;
    src_done_d = src_done_q;
    snk_done_d = snk_done_q;
    err_d      = err_q;

    if (w_busy && beat_valid_i && beat_ready_i && (beat_cnt_q != '1)) begin
      beat_cnt_d = beat_cnt_q + c_ONE;
    end
    if (state_q != c_IDLE) begin
      if (src_done_i) src_done_d = 1'b1;
      if (snk_done_i) snk_done_d = 1'b1;
      // A sink completion before its start went out means the streamer is out of step.
      if (snk_done_i && snk_pend_q && !w_snk_issue) err_d = 1'b1;
    end
    if (w_src_issue) src_pend_d = 1'b0;
    if (w_snk_issue) snk_pend_d = 1'b0;

    case (state_q)
      c_IDLE: begin
        if (start_i) begin
          src_addr_d = src_addr_i;
          dst_addr_d = dst_addr_i;
          len_d      = len_i;
          beat_cnt_d = '0;
          src_pend_d = (len_i != '0);
          snk_pend_d = (len_i != '0);
          src_done_d = 1'b0;
          snk_done_d = 1'b0;
          err_d      = 1'b0;
          state_d    = (len_i != '0) ? c_ISSUE : c_DONE;
        end
      end
      c_ISSUE: begin
        if ((!src_pend_q || w_src_issue) && (!snk_pend_q || w_snk_issue)) state_d = c_RUN;
      end
      c_RUN: begin
        if (src_done_q && snk_done_q) state_d = c_DRAIN;
      end
      c_DRAIN: begin
        if (tcdm_fifo_empty_i) begin
          state_d = c_DONE;
          if (beat_cnt_q != len_q) err_d = 1'b1;
        end
      end
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase

    if (clear_i) begin
      state_d    = c_IDLE;
      src_addr_d = '0;
      dst_addr_d = '0;
      len_d      = '0;
      beat_cnt_d = '0;
      src_pend_d = 1'b0;
      snk_pend_d = 1'b0;
      src_done_d = 1'b0;
      snk_done_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_comb begin
    busy_o          = w_busy;
    done_o          = (state_q == c_DONE);
    err_o           = err_q;
    beat_cnt_o      = beat_cnt_q;
    src_req_start_o = w_src_issue;
    snk_req_start_o = w_snk_issue;
    src_base_addr_o = src_addr_q;
    snk_base_addr_o = dst_addr_q;
    src_tot_len_o   = len_q;
    snk_tot_len_o   = len_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_datamover_ctrl_fsm.sv
// ======================================================================
// tb_datamover_ctrl_fsm: scoreboard bench for datamover_ctrl_fsm
// Revision: 1.0 - initial release
// ======================================================================
`default_nettype none

module tb_datamover_ctrl_fsm;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        start_i;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [15:0] len_i;
  logic        src_req_start_o, snk_req_start_o;
  logic [31:0] src_base_addr_o, snk_base_addr_o;
  logic [15:0] src_tot_len_o, snk_tot_len_o;
  logic        src_ready_start_i, snk_ready_start_i;
  logic        src_done_i, snk_done_i;
  logic        tcdm_fifo_empty_i;
  logic        beat_valid_i, beat_ready_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] beat_cnt_o;

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] beats;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
  } done_exp_t;

  int        src_q[$];
  int        snk_q[$];
  done_exp_t done_q[$];
  int        cyc = 0;
  int        n_cmp = 0;
  int        n_bad = 0;

  datamover_ctrl_fsm #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .src_req_start_o(src_req_start_o), .snk_req_start_o(snk_req_start_o),
    .src_base_addr_o(src_base_addr_o), .snk_base_addr_o(snk_base_addr_o),
    .src_tot_len_o(src_tot_len_o), .snk_tot_len_o(snk_tot_len_o),
    .src_ready_start_i(src_ready_start_i), .snk_ready_start_i(snk_ready_start_i),
    .src_done_i(src_done_i), .snk_done_i(snk_done_i),
    .tcdm_fifo_empty_i(tcdm_fifo_empty_i),
    .beat_valid_i(beat_valid_i), .beat_ready_i(beat_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .beat_cnt_o(beat_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT output event is matched against the next queued expectation.
  always @(negedge clk_i) begin
    done_exp_t e;
    if (src_req_start_o === 1'b1) begin
      if (src_q.size() == 0) check("src_req_unexpected", 64'(src_req_start_o), 64'd0);
      else                   check("src_req_cycle", 64'(cyc), 64'(src_q.pop_front()));
    end
    if (snk_req_start_o === 1'b1) begin
      if (snk_q.size() == 0) check("snk_req_unexpected", 64'(snk_req_start_o), 64'd0);
      else                   check("snk_req_cycle", 64'(cyc), 64'(snk_q.pop_front()));
    end
    if (done_o === 1'b1) begin
      if (done_q.size() == 0) check("done_unexpected", 64'(done_o), 64'd0);
      else begin
        e = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("done_err", 64'(err_o), 64'(e.err));
        check("done_beats", 64'(beat_cnt_o), 64'(e.beats));
        if (e.len != 16'd0) begin
          check("done_src_base", 64'(src_base_addr_o), 64'(e.src));
          check("done_snk_base", 64'(snk_base_addr_o), 64'(e.dst));
          check("done_src_len", 64'(src_tot_len_o), 64'(e.len));
          check("done_snk_len", 64'(snk_tot_len_o), 64'(e.len));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},     64'(busy_o), 64'd0);
    check({tag, "_done"},     64'(done_o), 64'd0);
    check({tag, "_err"},      64'(err_o), 64'd0);
    check({tag, "_beats"},    64'(beat_cnt_o), 64'd0);
    check({tag, "_src_base"}, 64'(src_base_addr_o), 64'd0);
    check({tag, "_snk_base"}, 64'(snk_base_addr_o), 64'd0);
    check({tag, "_src_len"},  64'(src_tot_len_o), 64'd0);
    check({tag, "_snk_len"},  64'(snk_tot_len_o), 64'd0);
    check({tag, "_src_req"},  64'(src_req_start_o), 64'd0);
    check({tag, "_snk_req"},  64'(snk_req_start_o), 64'd0);
  endtask

  task automatic idle_inputs;
    start_i = 1'b0; clear_i = 1'b0;
    src_ready_start_i = 1'b1; snk_ready_start_i = 1'b1;
    src_done_i = 1'b0; snk_done_i = 1'b0;
    tcdm_fifo_empty_i = 1'b1;
    beat_valid_i = 1'b0; beat_ready_i = 1'b0;
  endtask

  // nb beats, sink ready delayed sd cycles, FIFO non-empty f cycles in DRAIN,
  // done_o expected off cycles after start; early pulses snk_done while sink start pending.
  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                         input int nb, input int sd, input int f, input int off,
                         input bit early, input bit exp_err);
    int        t;
    int        dd;
    done_exp_t e;
    t = cyc;
    start_i = 1'b1; src_addr_i = s; dst_addr_i = d; len_i = l;
    if (l != 16'd0) begin
      src_q.push_back(t + 1);
      snk_q.push_back(t + 1 + sd);
    end
    e.cyc = t + off; e.err = exp_err; e.beats = 16'(nb); e.src = s; e.dst = d; e.len = l;
    done_q.push_back(e);
    dd = ((nb > sd + 1) ? nb : sd + 1) + 1;
    for (int c = 1; c <= off; c++) begin
      tick();
      start_i = 1'b0;
      check("busy_in_job", 64'(busy_o), (c < off) ? 64'd1 : 64'd0);
      if (c == 1) check("err_cleared_by_start", 64'(err_o), 64'd0);
      snk_ready_start_i = (c > sd);
      beat_valid_i = (c <= nb);
      beat_ready_i = (c <= nb);
      src_done_i = (l != 16'd0) && (c == dd);
      snk_done_i = (l != 16'd0) && ((c == dd) || (early && c == 1));
      tcdm_fifo_empty_i = !((l != 16'd0) && (c >= dd + 2) && (c < dd + 2 + f));
    end
    tick();
    idle_inputs();
    check("busy_after_job", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int t;
    rst_ni = 1'b0;
    src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    idle_inputs();
    repeat (3) tick();
    check_zero("reset");
    rst_ni = 1'b1;
    tick();

    run_job(32'h100, 32'h200, 16'd8, 8, 0, 0, 12, 1'b0, 1'b0);
    run_job(32'h300, 32'h400, 16'd4, 4, 5, 0, 10, 1'b0, 1'b0);
    run_job(32'h500, 32'h600, 16'd0, 0, 0, 0,  1, 1'b0, 1'b0);
    run_job(32'h700, 32'h800, 16'd2, 2, 0, 3,  9, 1'b0, 1'b0);
    run_job(32'h900, 32'hA00, 16'd4, 3, 0, 0,  7, 1'b0, 1'b1);
    run_job(32'hB00, 32'hC00, 16'd4, 4, 3, 0,  8, 1'b1, 1'b1);
    check("err_sticky_in_idle", 64'(err_o), 64'd1);

    // Soft clear while in RUN.
    t = cyc;
    start_i = 1'b1; src_addr_i = 32'h1000; dst_addr_i = 32'h2000; len_i = 16'd8;
    src_q.push_back(t + 1);
    snk_q.push_back(t + 1);
    tick(); start_i = 1'b0;
    tick();
    tick(); clear_i = 1'b1;
    tick(); clear_i = 1'b0;
    check_zero("clear");

    // Reset while the sink start is still pending in ISSUE.
    t = cyc;
    start_i = 1'b1; src_addr_i = 32'h3000; dst_addr_i = 32'h4000; len_i = 16'd6;
    snk_ready_start_i = 1'b0;
    src_q.push_back(t + 1);
    tick(); start_i = 1'b0;
    tick(); rst_ni = 1'b0; snk_ready_start_i = 1'b1;
    tick();
    check_zero("abort_rst");
    tick(); rst_ni = 1'b1;
    tick();

    run_job(32'hD00, 32'hE00, 16'd5, 5, 2, 1, 10, 1'b0, 1'b0);
    repeat (3) tick();

    check("src_q_drained", 64'(src_q.size()), 64'd0);
    check("snk_q_drained", 64'(snk_q.size()), 64'd0);
    check("done_q_drained", 64'(done_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

`default_nettype wire
